// File: rtl/dense_layer_par.sv
// dense_layer_par: fully-connected layer y = act(W*x + b).
// An input vector of IN_SIZE signed elements is streamed into a local buffer,
// then OUT_SIZE neurons are evaluated PAR at a time. Each group runs IN_SIZE
// multiply-accumulate steps against a PAR-wide weight word, is rounded back to
// DATA_FRAC fractional bits, biased, saturated, activated and presented on a
// valid/ready output port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, act_mode     begin a pass (IDLE only); activation 0/3 none, 1 ReLU, 2 leaky
//   busy, done          pass in progress; one-cycle end-of-pass pulse
//   in_data/valid/ready input element stream (ready only while loading)
//   weight_addr/data    synchronous weight ROM, data one cycle after address
//   bias_addr/data      synchronous bias ROM, data one cycle after address
//   out_data/valid/ready/out_grp  one PAR-wide result group per handshake
module dense_layer_par #(
  parameter int IN_SIZE      = 9,
  parameter int OUT_SIZE     = 4,
  parameter int PAR          = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int WEIGHT_FRAC  = 7,
  localparam int NGRP  = OUT_SIZE / PAR,
  localparam int WA_W  = (NGRP * IN_SIZE > 1) ? $clog2(NGRP * IN_SIZE) : 1,
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   act_mode,
  output logic                         busy,
  output logic                         done,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WA_W-1:0]              weight_addr,
  input  logic [PAR*WEIGHT_WIDTH-1:0]  weight_data,
  output logic [GRP_W-1:0]             bias_addr,
  input  logic [PAR*DATA_WIDTH-1:0]    bias_data,
  output logic [PAR*DATA_WIDTH-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [GRP_W-1:0]             out_grp
);

  localparam int CNT_W = $clog2(IN_SIZE + 1);
  localparam int ACC_W = DATA_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE) + 1;
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_BIAS = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(IN_SIZE);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGRP - 1);

  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(64'd1 << (WEIGHT_FRAC - 1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN  = -SAT_MAX - (ACC_W+1)'(1);
  localparam logic [DATA_WIDTH-1:0] OUT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]             state_reg;
  logic [1:0]             mode_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [GRP_W-1:0]       grp_reg;
  logic [WA_W-1:0]        waddr_reg;
  logic [DATA_WIDTH-1:0]  x_reg;
  logic [PAR*DATA_WIDTH-1:0] act_all;

  // Depth rounded up to a power of two so the counter can index it directly.
  logic [DATA_WIDTH-1:0]  buffer_mem [0:(1<<CNT_W)-1];

  assign busy        = (state_reg == S_LOAD) || (state_reg == S_MAC) ||
                       (state_reg == S_BIAS) || (state_reg == S_OUT);
  assign done        = (state_reg == S_DONE);
  assign in_ready    = (state_reg == S_LOAD);
  assign out_valid   = (state_reg == S_OUT);
  assign weight_addr = waddr_reg;
  assign bias_addr   = grp_reg;

  // Input buffer with registered read; x_reg lines up with the ROM latency so
  // element j and weight word j are both present in MAC cycle j+1.
  always_ff @(posedge clk) begin
    if (state_reg == S_LOAD && in_valid)
      buffer_mem[cnt_reg] <= in_data;
    if (state_reg == S_MAC)
      x_reg <= buffer_mem[cnt_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      mode_reg  <= 2'd0;
      cnt_reg   <= '0;
      grp_reg   <= '0;
      waddr_reg <= '0;
      out_data  <= '0;
      out_grp   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_LOAD;
            mode_reg  <= act_mode;
            cnt_reg   <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= S_MAC;
              cnt_reg   <= '0;
              grp_reg   <= '0;
              waddr_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        S_MAC: begin
          // Address stops on the group's last word; the final cycle only drains.
          if (cnt_reg < CNT_LAST)
            waddr_reg <= waddr_reg + WA_W'(1);
          if (cnt_reg == CNT_END)
            state_reg <= S_BIAS;
          else
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
        S_BIAS: begin
          out_data  <= act_all;
          out_grp   <= grp_reg;
          state_reg <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (grp_reg == GRP_LAST) begin
              state_reg <= S_DONE;
            end else begin
              grp_reg   <= grp_reg + GRP_W'(1);
              waddr_reg <= waddr_reg + WA_W'(1);
              cnt_reg   <= '0;
              state_reg <= S_MAC;
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PAR; gi++) begin : g_lane
      logic [WEIGHT_WIDTH-1:0]  w_lane;
      logic [DATA_WIDTH-1:0]    b_lane;
      logic [PROD_W-1:0]        prod;
      logic [ACC_W-1:0]         acc_reg;
      logic [ACC_W:0]           acc_ext;
      logic [ACC_W:0]           bias_ext;
      logic signed [ACC_W:0]    rnd;
      logic signed [ACC_W:0]    sum;
      logic [DATA_WIDTH-1:0]    sat;
      logic [DATA_WIDTH-1:0]    act;

      assign w_lane = weight_data[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign b_lane = bias_data[gi*DATA_WIDTH +: DATA_WIDTH];

      // Operands sign-extended to the product width; the low PROD_W bits of
      // that unsigned product are the exact two's-complement signed product.
      assign prod = {{WEIGHT_WIDTH{x_reg[DATA_WIDTH-1]}}, x_reg} *
                    {{DATA_WIDTH{w_lane[WEIGHT_WIDTH-1]}}, w_lane};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          acc_reg <= '0;
        else if (state_reg != S_MAC)
          acc_reg <= '0;
        else if (cnt_reg != '0)
          acc_reg <= acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      end

      always_comb begin
        acc_ext  = {acc_reg[ACC_W-1], acc_reg};
        bias_ext = {{(ACC_W+1-DATA_WIDTH){b_lane[DATA_WIDTH-1]}}, b_lane};
        // Round half up back to the activation scale, then add bias.
        rnd = ($signed(acc_ext) + RND_HALF) >>> WEIGHT_FRAC;
        sum = rnd + $signed(bias_ext);
        if (sum > SAT_MAX)
          sat = OUT_MAX;
        else if (sum < SAT_MIN)
          sat = OUT_MIN;
        else
          sat = sum[DATA_WIDTH-1:0];
        act = sat;
        if (sat[DATA_WIDTH-1]) begin
          if (mode_reg == 2'd1)
            act = '0;
          else if (mode_reg == 2'd2)
            act = $signed(sat) >>> 3;
        end
      end

      assign act_all[gi*DATA_WIDTH +: DATA_WIDTH] = act;
    end
  endgenerate

endmodule

// File: tb/tb_dense_layer_par.sv
// Self-checking bench for dense_layer_par (IN_SIZE=3, OUT_SIZE=4, PAR=2).
// Weight/bias ROMs are modelled as synchronous arrays; expected results come
// from an integer-arithmetic model of y = act(sat(round(W*x) + b)).
module tb_dense_layer_par;
  localparam int IN_SIZE = 3;
  localparam int OUT_SIZE = 4;
  localparam int PAR = 2;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int WF = 7;
  localparam int NGRP = OUT_SIZE / PAR;
  localparam int WA_W = $clog2(NGRP * IN_SIZE);
  localparam int GRP_W = 1;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic [1:0] act_mode = 0;
  logic busy, done, in_ready, out_valid;
  logic [DW-1:0] in_data = 0;
  logic in_valid = 0;
  logic [WA_W-1:0] weight_addr;
  logic [PAR*WW-1:0] weight_data;
  logic [GRP_W-1:0] bias_addr;
  logic [PAR*DW-1:0] bias_data;
  logic [PAR*DW-1:0] out_data;
  logic out_ready = 0;
  logic [GRP_W-1:0] out_grp;

  dense_layer_par #(
    .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .PAR(PAR), .DATA_WIDTH(DW),
    .DATA_FRAC(8), .WEIGHT_WIDTH(WW), .WEIGHT_FRAC(WF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_mode(act_mode),
    .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .weight_addr(weight_addr), .weight_data(weight_data),
    .bias_addr(bias_addr), .bias_data(bias_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_grp(out_grp)
  );

  always #5 clk = ~clk;

  logic [PAR*WW-1:0] w_rom [NGRP*IN_SIZE];
  logic [PAR*DW-1:0] b_rom [NGRP];
  logic signed [DW-1:0] x_vec [IN_SIZE];

  always @(posedge clk) begin
    weight_data <= w_rom[weight_addr];
    bias_data   <= b_rom[bias_addr];
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_count = 0;
  int done_count = 0;

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) accept_count++;
    if (done === 1'b1) done_count++;
  end

  // Results of the most recent pass
  logic [PAR*DW-1:0] got_data [NGRP];
  logic [GRP_W-1:0]  got_grp [NGRP];
  int t_valid [NGRP];
  int accept_edge, last_hs_edge, done_at, pass_done;
  logic busy_at_done;
  bit timed_out, stable_ok;

  function automatic logic [PAR*DW-1:0] model_group(input int g, input int mode);
    logic [PAR*DW-1:0] r;
    logic [WW-1:0] wb;
    logic [DW-1:0] bb;
    longint acc, v;
    longint vmax = (longint'(1) <<< (DW - 1)) - 1;
    r = '0;
    for (int k = 0; k < PAR; k++) begin
      acc = 0;
      for (int i = 0; i < IN_SIZE; i++) begin
        wb = w_rom[g*IN_SIZE + i][k*WW +: WW];
        acc += longint'(x_vec[i]) * longint'($signed(wb));
      end
      v = (acc + (longint'(1) <<< (WF - 1))) >>> WF;
      bb = b_rom[g][k*DW +: DW];
      v += longint'($signed(bb));
      if (v > vmax) v = vmax;
      if (v < -vmax - 1) v = -vmax - 1;
      if (mode == 1 && v < 0) v = 0;
      else if (mode == 2 && v < 0) v = v >>> 3;
      r[k*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  task automatic fill_rom(input logic [WW-1:0] w, input logic [DW-1:0] b);
    for (int a = 0; a < NGRP*IN_SIZE; a++) w_rom[a] = {PAR{w}};
    for (int g = 0; g < NGRP; g++) b_rom[g] = {PAR{b}};
  endtask

  // Pulse start, then stream x_vec; act_mode is scrambled after acceptance.
  task automatic start_and_feed(input logic [1:0] mode, input bit gaps);
    int idx, guard;
    bit tog;
    timed_out = 0;
    @(negedge clk);
    start = 1; act_mode = mode;
    @(negedge clk);
    start = 0;
    idx = 0; guard = 0; tog = 0;
    while (idx < IN_SIZE && guard < 200) begin
      act_mode = 2'($urandom);
      start = (gaps && guard == 1);
      if (gaps && tog) begin
        in_valid = 0; in_data = DW'($urandom);
      end else begin
        in_valid = 1; in_data = x_vec[idx];
      end
      tog = !tog;
      if (in_valid && in_ready) begin
        idx++;
        if (idx == IN_SIZE) accept_edge = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    start = 0;
    in_valid = 0;
    if (gaps) begin
      for (int e = 0; e < 3; e++) begin
        in_valid = tog; tog = !tog; in_data = DW'($urandom);
        @(negedge clk);
      end
      in_valid = 0;
    end
    if (guard >= 200) timed_out = 1;
  endtask

  // Consume NGRP groups; stall0 holds out_ready low on group 0, rnd randomises stalls.
  task automatic collect(input int stall0, input bit rnd);
    int g, guard, stall_left, d0;
    bit seen;
    logic [PAR*DW-1:0] s_d;
    logic [GRP_W-1:0] s_g, s_b;
    logic [WA_W-1:0] s_w;
    g = 0; guard = 0; seen = 0; stable_ok = 1; d0 = done_count;
    stall_left = rnd ? $urandom_range(0, 3) : stall0;
    while (g < NGRP && guard < 500) begin
      if (out_valid) begin
        if (!seen) begin
          seen = 1; t_valid[g] = cyc;
          s_d = out_data; s_g = out_grp; s_w = weight_addr; s_b = bias_addr;
        end else if (out_data !== s_d || out_grp !== s_g || weight_addr !== s_w || bias_addr !== s_b) begin
          stable_ok = 0;
        end
        if (stall_left > 0) begin
          out_ready = 0; stall_left--;
        end else begin
          out_ready = 1;
          got_data[g] = out_data; got_grp[g] = out_grp;
          last_hs_edge = cyc + 1;
          g++; seen = 0;
          stall_left = rnd ? $urandom_range(0, 3) : 0;
        end
      end else begin
        out_ready = rnd ? 1'($urandom) : 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 0;
    if (guard >= 500) timed_out = 1;
    done_at = -1; busy_at_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1 && done_at < 0) begin done_at = cyc; busy_at_done = busy; end
      @(negedge clk);
    end
    pass_done = done_count - d0;
  endtask

  task automatic run_pass(input logic [1:0] mode, input bit gaps, input int stall0, input bit rnd);
    start_and_feed(mode, gaps);
    if (!timed_out) collect(stall0, rnd);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, in_ready, out_valid, out_grp, bias_addr, weight_addr, out_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b in_ready=%b out_valid=%b out_data=%h grp=%h waddr=%h baddr=%h want all zero",
               busy, done, in_ready, out_valid, out_data, out_grp, weight_addr, bias_addr);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [PAR*DW-1:0] exp_d;
    for (int i = 0; i < IN_SIZE; i++) x_vec[i] = 16'sh0100;
    fill_rom(8'h40, 16'h0080);
    run_pass(2'd0, 0, 0, 0);
    n_vec++;
    if (timed_out) begin n_bad++; $display("FAIL basic_timeout: got timeout want completion"); end
    exp_d = {PAR{16'h0200}};
    for (int g = 0; g < NGRP; g++) begin
      n_vec++;
      if (got_data[g] !== exp_d) begin n_bad++; $display("FAIL basic_data g%0d: got %h want %h", g, got_data[g], exp_d); end
      n_vec++;
      if (got_grp[g] !== GRP_W'(g)) begin n_bad++; $display("FAIL basic_grp g%0d: got %0d want %0d", g, got_grp[g], g); end
    end
    n_vec++;
    if (t_valid[0] - accept_edge !== IN_SIZE + 2) begin
      n_bad++; $display("FAIL first_latency: got %0d want %0d", t_valid[0] - accept_edge, IN_SIZE + 2);
    end
    n_vec++;
    if (t_valid[1] - t_valid[0] !== IN_SIZE + 3) begin
      n_bad++; $display("FAIL group_spacing: got %0d want %0d", t_valid[1] - t_valid[0], IN_SIZE + 3);
    end
    n_vec++;
    if (pass_done !== 1) begin n_bad++; $display("FAIL done_count: got %0d want 1", pass_done); end
    n_vec++;
    if (done_at !== last_hs_edge || busy_at_done !== 1'b0) begin
      n_bad++; $display("FAIL done_timing: got cycle %0d busy=%b want cycle %0d busy=0", done_at, busy_at_done, last_hs_edge);
    end
  endtask

  task automatic test_rounding;
    logic [WW-1:0] wv [2];
    logic [DW-1:0] ev [2];
    wv[0] = 8'h40; ev[0] = 16'h0001;
    wv[1] = 8'hC0; ev[1] = 16'h0000;
    x_vec[0] = 16'sh0001; x_vec[1] = 0; x_vec[2] = 0;
    for (int t = 0; t < 2; t++) begin
      fill_rom(wv[t], 16'h0000);
      run_pass(2'd0, 0, 0, 0);
      for (int g = 0; g < NGRP; g++) begin
        n_vec++;
        if (got_data[g] !== {PAR{ev[t]}} || timed_out) begin
          n_bad++; $display("FAIL rounding w=%h g%0d: got %h want %h", wv[t], g, got_data[g], {PAR{ev[t]}});
        end
      end
    end
  endtask

  task automatic test_saturation;
    logic [WW-1:0] wv [4];
    logic [1:0] mv [4];
    logic [DW-1:0] ev [4];
    wv[0] = 8'h7F; mv[0] = 2'd0; ev[0] = 16'h7FFF;
    wv[1] = 8'h80; mv[1] = 2'd0; ev[1] = 16'h8000;
    wv[2] = 8'h80; mv[2] = 2'd1; ev[2] = 16'h0000;
    wv[3] = 8'h80; mv[3] = 2'd2; ev[3] = 16'hF000;
    for (int i = 0; i < IN_SIZE; i++) x_vec[i] = 16'sh7FFF;
    for (int t = 0; t < 4; t++) begin
      fill_rom(wv[t], 16'h0000);
      run_pass(mv[t], 0, 0, 0);
      n_vec++;
      if (got_data[1] !== {PAR{ev[t]}} || timed_out) begin
        n_bad++; $display("FAIL saturation w=%h mode=%0d: got %h want %h", wv[t], mv[t], got_data[1], {PAR{ev[t]}});
      end
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < IN_SIZE; i++) x_vec[i] = 16'sh0100;
    fill_rom(8'h40, 16'h0080);
    run_pass(2'd0, 0, 5, 0);
    n_vec++;
    if (stable_ok !== 1'b1) begin n_bad++; $display("FAIL stall_stability: got unstable outputs want stable"); end
    for (int g = 0; g < NGRP; g++) begin
      n_vec++;
      if (got_data[g] !== {PAR{16'h0200}} || got_grp[g] !== GRP_W'(g) || timed_out) begin
        n_bad++; $display("FAIL stall_data g%0d: got %h grp %0d want %h grp %0d", g, got_data[g], got_grp[g], {PAR{16'h0200}}, g);
      end
    end
  endtask

  task automatic test_input_gaps;
    int a0;
    for (int i = 0; i < IN_SIZE; i++) x_vec[i] = 16'sh0100;
    fill_rom(8'h40, 16'h0080);
    a0 = accept_count;
    run_pass(2'd0, 1, 0, 0);
    n_vec++;
    if (accept_count - a0 !== IN_SIZE) begin
      n_bad++; $display("FAIL gap_accepts: got %0d want %0d", accept_count - a0, IN_SIZE);
    end
    for (int g = 0; g < NGRP; g++) begin
      n_vec++;
      if (got_data[g] !== {PAR{16'h0200}} || timed_out) begin
        n_bad++; $display("FAIL gap_data g%0d: got %h want %h", g, got_data[g], {PAR{16'h0200}});
      end
    end
  endtask

  task automatic test_random;
    logic [PAR*DW-1:0] exp_d;
    int mode;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < IN_SIZE; i++) x_vec[i] = DW'($urandom_range(0, 4095)) - 16'sd2048;
      for (int a = 0; a < NGRP*IN_SIZE; a++) w_rom[a] = (PAR*WW)'($urandom);
      for (int g = 0; g < NGRP; g++)
        for (int k = 0; k < PAR; k++) b_rom[g][k*DW +: DW] = DW'($urandom_range(0, 8191)) - 16'd4096;
      mode = $urandom_range(0, 3);
      run_pass(2'(mode), p[0], 0, 1);
      for (int g = 0; g < NGRP; g++) begin
        exp_d = model_group(g, mode);
        n_vec++;
        if (got_data[g] !== exp_d || got_grp[g] !== GRP_W'(g) || timed_out) begin
          n_bad++; $display("FAIL random p%0d mode%0d g%0d: got %h grp %0d want %h grp %0d", p, mode, g, got_data[g], got_grp[g], exp_d, g);
        end
      end
      n_vec++;
      if (pass_done !== 1) begin n_bad++; $display("FAIL random_done p%0d: got %0d want 1", p, pass_done); end
    end
  endtask

  task automatic test_reset_mid_pass;
    int guard, d0;
    for (int i = 0; i < IN_SIZE; i++) x_vec[i] = 16'sh0100;
    fill_rom(8'h40, 16'h0080);
    d0 = done_count;
    start_and_feed(2'd0, 0);
    out_ready = 1;
    guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (guard >= 50 || weight_addr !== WA_W'(IN_SIZE + 1) || busy !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_mac: got waddr %0d busy %b want waddr %0d busy 1", weight_addr, busy, IN_SIZE + 1);
    end
    rst_n = 0;
    #1;
    n_vec++;
    if ({busy, done, in_ready, out_valid, out_grp, bias_addr, weight_addr, out_data} !== '0) begin
      n_bad++; $display("FAIL async_reset: got busy=%b out_valid=%b out_data=%h waddr=%h want all zero", busy, out_valid, out_data, weight_addr);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done, in_ready, out_valid, out_grp, bias_addr, weight_addr, out_data} !== '0) begin
      n_bad++; $display("FAIL reset_hold: got busy=%b out_valid=%b out_data=%h waddr=%h want all zero", busy, out_valid, out_data, weight_addr);
    end
    out_ready = 0;
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (done_count !== d0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL residual_after_reset: got done pulses %0d out_valid %b want 0 0", done_count - d0, out_valid);
    end
    run_pass(2'd0, 0, 0, 0);
    for (int g = 0; g < NGRP; g++) begin
      n_vec++;
      if (got_data[g] !== {PAR{16'h0200}} || got_grp[g] !== GRP_W'(g) || timed_out) begin
        n_bad++; $display("FAIL post_reset g%0d: got %h want %h", g, got_data[g], {PAR{16'h0200}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_input_gaps();
    test_random();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
